// File: rtl/fc_pkg.sv
// Shared types, constants and arithmetic helpers for the FC classifier slice.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        HOLD   = 2'd3
    } fc_state_e;

    // Bias is stored in WW bits but lands in the accumulator scaled by 2^BIAS_SHIFT.
    localparam int unsigned BIAS_SHIFT = 4;

    // Wide enough to hold any accumulator plus any lane sum without overflow.
    localparam int unsigned SAT_W = 64;

    localparam int unsigned DEF_N_FEAT  = 64;
    localparam int unsigned DEF_LANES   = 4;
    localparam int unsigned DEF_N_CLASS = 4;
    localparam int unsigned DEF_CLS_W   = $clog2(DEF_N_CLASS);
    localparam int unsigned DEF_ADDR_W  = $clog2(DEF_N_FEAT);

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lane-sum width: full product growth, never narrower than the accumulator.
    function automatic int unsigned dot_w(input int unsigned lanes, input int unsigned dw,
                                          input int unsigned ww, input int unsigned accw);
        int unsigned nat;
        nat = dw + ww + idx_w(lanes);
        return (nat > accw) ? nat : accw;
    endfunction

    // Signed add clamped to the range of an accw-bit two's-complement value.
    function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                        input logic signed [SAT_W-1:0] b,
                                                        input int unsigned accw);
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (accw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (accw - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/fc_classifier_param_if.sv
// Stream-in / result-out / coefficient-write bundle for fc_classifier_param.
interface fc_classifier_param_if
    import fc_pkg::*;
#(
    parameter int unsigned N_FEAT  = DEF_N_FEAT,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned N_CLASS = DEF_N_CLASS,
    parameter int unsigned DW      = 8,
    parameter int unsigned WW      = 8,
    parameter int unsigned ACCW    = 24
);
    localparam int unsigned CLS_W  = idx_w(N_CLASS);
    localparam int unsigned ADDR_W = idx_w(N_FEAT);

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*DW-1:0]    in_data;

    logic                   w_we;
    logic [CLS_W-1:0]       w_class;
    logic [ADDR_W-1:0]      w_addr;
    logic [WW-1:0]          w_data;

    logic                   b_we;
    logic [CLS_W-1:0]       b_class;
    logic [WW-1:0]          b_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [CLS_W-1:0]       out_class;
    logic [ACCW-1:0]        out_score;
    logic                   busy;

    modport master (
        output in_valid, in_data, w_we, w_class, w_addr, w_data, b_we, b_class, b_data,
        output out_ready,
        input  in_ready, out_valid, out_class, out_score, busy
    );

    modport slave (
        input  in_valid, in_data, w_we, w_class, w_addr, w_data, b_we, b_class, b_data,
        input  out_ready,
        output in_ready, out_valid, out_class, out_score, busy
    );

endinterface

// File: rtl/fc_dot_lanes.sv
// Combinational LANES-wide signed dot product of one input beat against one weight slice.
module fc_dot_lanes
    import fc_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned WW    = 8,
    parameter int unsigned ACCW  = 24,
    localparam int unsigned OW   = dot_w(LANES, DW, WW, ACCW)
) (
    input  logic [LANES*DW-1:0]  act,
    input  logic [LANES*WW-1:0]  wgt,
    output logic signed [OW-1:0] sum
);

    logic signed [DW+WW-1:0] prod [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prod[l] = $signed(act[l*DW +: DW]) * $signed(wgt[l*WW +: WW]);
    end

    // Sign-extend each product and add; OW is sized so this never overflows.
    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            sum = sum + OW'(prod[l]);
        end
    end

endmodule

// File: rtl/fc_classifier_param.sv
// Parametrised FC classification layer: streamed dot products, saturating accumulate,
// sequential argmax, result held until the downstream handshake.
module fc_classifier_param
    import fc_pkg::*;
#(
    parameter int unsigned N_FEAT  = DEF_N_FEAT,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned N_CLASS = DEF_N_CLASS,
    parameter int unsigned DW      = 8,
    parameter int unsigned WW      = 8,
    parameter int unsigned ACCW    = 24
) (
    input logic                  clk,
    input logic                  rst,
    fc_classifier_param_if.slave bus
);

    localparam int unsigned N_BEATS = N_FEAT / LANES;
    localparam int unsigned BEAT_W  = idx_w(N_BEATS);
    localparam int unsigned CLS_W   = idx_w(N_CLASS);
    localparam int unsigned OW      = dot_w(LANES, DW, WW, ACCW);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
    localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(N_CLASS - 1);

    fc_state_e               state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic signed [ACCW-1:0]  acc_q [N_CLASS];
    logic signed [ACCW-1:0]  acc_d [N_CLASS];
    logic [CLS_W-1:0]        scan_q, scan_d;
    logic [CLS_W-1:0]        best_idx_q, best_idx_d;
    logic signed [ACCW-1:0]  best_q, best_d;
    logic [CLS_W-1:0]        out_class_q, out_class_d;
    logic signed [ACCW-1:0]  out_score_q, out_score_d;
    logic                    out_valid_q, out_valid_d;
    logic                    alive_q;

    logic [N_FEAT*WW-1:0]    w_q [N_CLASS];
    logic signed [WW-1:0]    b_q [N_CLASS];

    logic [LANES*WW-1:0]     w_beat [N_CLASS];
    logic signed [OW-1:0]    dot [N_CLASS];

    logic                    in_ready;
    logic                    accept;
    logic                    coef_ok;

    function automatic logic signed [ACCW-1:0] acc_add(input logic signed [SAT_W-1:0] a,
                                                       input logic signed [SAT_W-1:0] b);
        logic signed [SAT_W-1:0] s;
        s = sat_add(a, b, ACCW);
        return s[ACCW-1:0];
    endfunction

    // alive_q keeps in_ready low through the reset cycle.
    assign in_ready = alive_q && (state_q == IDLE || state_q == ACCUM);
    assign accept   = bus.in_valid && in_ready;
    assign coef_ok  = alive_q && (state_q == IDLE);

    for (genvar c = 0; c < N_CLASS; c++) begin : g_cls
        assign w_beat[c] = w_q[c][int'(beat_q) * int'(LANES * WW) +: LANES * WW];

        fc_dot_lanes #(
            .LANES (LANES),
            .DW    (DW),
            .WW    (WW),
            .ACCW  (ACCW)
        ) u_dot (
            .act (bus.in_data),
            .wgt (w_beat[c]),
            .sum (dot[c])
        );
    end

    // Next-state, accumulate and argmax scan.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
        scan_d      = scan_q;
        best_idx_d  = best_idx_q;
        best_d      = best_q;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // First beat seeds each accumulator with its scaled bias.
                    for (int c = 0; c < N_CLASS; c++) begin
                        acc_d[c] = acc_add(SAT_W'(b_q[c]) <<< BIAS_SHIFT, SAT_W'(dot[c]));
                    end
                    scan_d = '0;
                    if (N_BEATS == 1) begin
                        beat_d  = '0;
                        state_d = ARGMAX;
                    end else begin
                        beat_d  = BEAT_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    for (int c = 0; c < N_CLASS; c++) begin
                        acc_d[c] = acc_add(SAT_W'(acc_q[c]), SAT_W'(dot[c]));
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        scan_d  = '0;
                        state_d = ARGMAX;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ARGMAX: begin
                // Strictly greater only, so ties keep the lower index.
                if (scan_q == '0 || acc_q[scan_q] > best_q) begin
                    best_idx_d = scan_q;
                    best_d     = acc_q[scan_q];
                end
                if (scan_q == LAST_CLS) begin
                    out_class_d = best_idx_d;
                    out_score_d = best_d;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    for (int c = 0; c < N_CLASS; c++) begin
                        acc_d[c] = '0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            scan_q      <= '0;
            best_idx_q  <= '0;
            best_q      <= '0;
            out_class_q <= '0;
            out_score_q <= '0;
            out_valid_q <= 1'b0;
            alive_q     <= 1'b0;
            for (int c = 0; c < N_CLASS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            scan_q      <= scan_d;
            best_idx_q  <= best_idx_d;
            best_q      <= best_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
            out_valid_q <= out_valid_d;
            alive_q     <= 1'b1;
            acc_q       <= acc_d;
        end
    end

    // Coefficient storage; writes only land while idle and in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CLASS; c++) begin
                w_q[c] <= '0;
                b_q[c] <= '0;
            end
        end else if (coef_ok) begin
            for (int c = 0; c < N_CLASS; c++) begin
                if (bus.w_we && c == int'(bus.w_class) && int'(bus.w_addr) < int'(N_FEAT)) begin
                    w_q[c][int'(bus.w_addr) * int'(WW) +: WW] <= bus.w_data;
                end
                if (bus.b_we && c == int'(bus.b_class)) begin
                    b_q[c] <= bus.b_data;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fc_classifier_param.sv
// Bench for fc_classifier_param: two instances (ACCW=24 and ACCW=16) driven in lockstep,
// vector table of coefficient/activation sets, scoreboard queues checked on each result.
module tb_fc_classifier_param;

    localparam int unsigned N_FEAT  = 64;
    localparam int unsigned LANES   = 4;
    localparam int unsigned N_CLASS = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned WW      = 8;
    localparam int unsigned N_BEATS = N_FEAT / LANES;
    localparam int          TIMEOUT = 200;

    typedef struct packed {
        logic [3:0][7:0]    w;
        logic [3:0][7:0]    b;
        logic [7:0]         act;
        logic               gaps;
        logic [1:0]         cls;
        logic signed [31:0] s24;
        logic signed [31:0] s16;
    } vec_t;

    typedef struct packed {
        logic [1:0]         cls;
        logic signed [31:0] score;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic                in_valid;
    logic [LANES*DW-1:0] in_data;
    logic                w_we;
    logic [1:0]          w_class;
    logic [5:0]          w_addr;
    logic [7:0]          w_data;
    logic                b_we;
    logic [1:0]          b_class;
    logic [7:0]          b_data;
    logic                out_ready;

    int   checks = 0;
    int   errors = 0;
    res_t sb24[$];
    res_t sb16[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    fc_classifier_param_if #(.N_FEAT(N_FEAT), .LANES(LANES), .N_CLASS(N_CLASS), .DW(DW),
                             .WW(WW), .ACCW(24)) bus24 ();
    fc_classifier_param_if #(.N_FEAT(N_FEAT), .LANES(LANES), .N_CLASS(N_CLASS), .DW(DW),
                             .WW(WW), .ACCW(16)) bus16 ();

    fc_classifier_param #(.N_FEAT(N_FEAT), .LANES(LANES), .N_CLASS(N_CLASS), .DW(DW),
                          .WW(WW), .ACCW(24)) u_dut24 (.clk(clk), .rst(rst), .bus(bus24));
    fc_classifier_param #(.N_FEAT(N_FEAT), .LANES(LANES), .N_CLASS(N_CLASS), .DW(DW),
                          .WW(WW), .ACCW(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    assign bus24.in_valid  = in_valid;
    assign bus24.in_data   = in_data;
    assign bus24.w_we      = w_we;
    assign bus24.w_class   = w_class;
    assign bus24.w_addr    = w_addr;
    assign bus24.w_data    = w_data;
    assign bus24.b_we      = b_we;
    assign bus24.b_class   = b_class;
    assign bus24.b_data    = b_data;
    assign bus24.out_ready = out_ready;
    assign bus16.in_valid  = in_valid;
    assign bus16.in_data   = in_data;
    assign bus16.w_we      = w_we;
    assign bus16.w_class   = w_class;
    assign bus16.w_addr    = w_addr;
    assign bus16.w_data    = w_data;
    assign bus16.b_we      = b_we;
    assign bus16.b_class   = b_class;
    assign bus16.b_data    = b_data;
    assign bus16.out_ready = out_ready;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound of %0d cycles expired (t=%0t)", name, TIMEOUT, $time);
    endtask

    function automatic vec_t mk(input int w0, input int w1, input int w2, input int w3,
                                input int b0, input int b1, input int b2, input int b3,
                                input int act, input bit gaps, input int cls,
                                input int s24, input int s16);
        vec_t v;
        v.w[0] = 8'(w0);
        v.w[1] = 8'(w1);
        v.w[2] = 8'(w2);
        v.w[3] = 8'(w3);
        v.b[0] = 8'(b0);
        v.b[1] = 8'(b1);
        v.b[2] = 8'(b2);
        v.b[3] = 8'(b3);
        v.act  = 8'(act);
        v.gaps = gaps;
        v.cls  = 2'(cls);
        v.s24  = s24;
        v.s16  = s16;
        return v;
    endfunction

    // Result monitor: one scoreboard pop per output handshake, per instance.
    always @(negedge clk) begin
        if (!rst && bus24.out_valid && bus24.out_ready) begin
            if (sb24.size() == 0) begin
                timed_out("sb24_unexpected_result");
            end else begin
                res_t e;
                e = sb24.pop_front();
                check("acc24_class", longint'(bus24.out_class), longint'(e.cls));
                check("acc24_score", $signed(bus24.out_score), e.score);
            end
        end
        if (!rst && bus16.out_valid && bus16.out_ready) begin
            if (sb16.size() == 0) begin
                timed_out("sb16_unexpected_result");
            end else begin
                res_t e;
                e = sb16.pop_front();
                check("acc16_class", longint'(bus16.out_class), longint'(e.cls));
                check("acc16_score", $signed(bus16.out_score), e.score);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (bus24.busy && guard < TIMEOUT) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= TIMEOUT) timed_out("wait_idle");
    endtask

    task automatic load_coeffs(input vec_t v);
        wait_idle();
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 64; a++) begin
                w_we    = 1'b1;
                w_class = 2'(c);
                w_addr  = 6'(a);
                w_data  = v.w[c];
                @(posedge clk);
                #1;
            end
        end
        w_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            b_we    = 1'b1;
            b_class = 2'(c);
            b_data  = v.b[c];
            @(posedge clk);
            #1;
        end
        b_we = 1'b0;
    endtask

    // Holds in_valid until the beat is taken; leaves in_valid high for back-to-back beats.
    task automatic send_beat(input logic [LANES*DW-1:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!bus24.in_ready && guard < TIMEOUT) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= TIMEOUT) timed_out("in_ready_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input bit wr_first);
        int lat;
        sb24.push_back('{cls: v.cls, score: v.s24});
        sb16.push_back('{cls: v.cls, score: v.s16});
        for (int k = 0; k < int'(N_BEATS); k++) begin
            if (v.gaps) begin
                int n;
                n = int'($urandom_range(0, 2));
                in_valid = 1'b0;
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (wr_first && k == 0) begin
                w_we    = 1'b1;
                w_class = 2'd0;
                w_addr  = 6'd0;
                w_data  = 8'd100;
            end
            send_beat({4{v.act}});
            w_we = 1'b0;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!bus24.out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("result_latency", lat, N_CLASS);
        check("hold_in_ready", longint'(bus24.in_ready), 0);
        check("hold_busy", longint'(bus24.busy), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 1'b0, 0, 64, 64);
        vecs[1] = mk(1, 1, 2, 1, 0, 10, 0, 0, 3, 1'b0, 2, 384, 384);
        vecs[2] = mk(1, 1, 2, 1, 0, 10, 0, 0, 3, 1'b1, 2, 384, 384);
        vecs[3] = mk(-1, 2, 0, 1, 0, 0, 20, 0, -2, 1'b0, 2, 320, 320);
        vecs[4] = mk(0, 3, 3, 1, 0, 0, 0, 0, 1, 1'b0, 1, 192, 192);
        vecs[5] = mk(-1, -2, -1, -3, 0, 0, 1, 0, 5, 1'b1, 2, -304, -304);
        vecs[6] = mk(127, 127, 127, 127, 0, 0, 0, 0, 127, 1'b0, 0, 1032256, 32767);
        vecs[7] = mk(127, 127, 127, 127, 0, 0, 0, 0, -128, 1'b0, 0, -1040384, -32768);

        in_valid  = 1'b0;
        in_data   = '0;
        w_we      = 1'b0;
        w_class   = '0;
        w_addr    = '0;
        w_data    = '0;
        b_we      = 1'b0;
        b_class   = '0;
        b_data    = '0;
        out_ready = 1'b1;

        // Reset values, observed asynchronously before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", longint'(bus24.out_valid), 0);
        check("rst_out_class", longint'(bus24.out_class), 0);
        check("rst_out_score", longint'(bus24.out_score), 0);
        check("rst_busy", longint'(bus24.busy), 0);
        check("rst_in_ready", longint'(bus24.in_ready), 0);
        check("rst_out_valid16", longint'(bus16.out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_held", longint'(bus24.in_ready), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", longint'(bus24.in_ready), 1);

        // Table frames: uniform, class-2 winner, gapped, mixed signs, ties.
        for (int i = 0; i < 6; i++) begin
            load_coeffs(vecs[i]);
            run_frame(vecs[i], 1'b0);
        end

        // Backpressure in HOLD; a weight write and a beat offered there must be ignored.
        load_coeffs(vecs[1]);
        out_ready = 1'b0;
        run_frame(vecs[1], 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                w_we     = 1'b1;
                w_class  = 2'd0;
                w_addr   = 6'd0;
                w_data   = 8'd100;
                in_valid = 1'b1;
                in_data  = {4{8'd3}};
            end else begin
                w_we     = 1'b0;
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp_out_valid", longint'(bus24.out_valid), 1);
            check("bp_out_class", longint'(bus24.out_class), 2);
            check("bp_out_score", $signed(bus24.out_score), 384);
            check("bp_in_ready", longint'(bus24.in_ready), 0);
        end
        w_we      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        run_frame(vecs[1], 1'b0);

        // Write coinciding with the first beat: this frame sees the old W[0][0]=1,
        // the next one sees 100, so class 0 scores 3*(63+100)=489.
        wait_idle();
        run_frame(vecs[1], 1'b1);
        run_frame(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1'b0, 0, 489, 489), 1'b0);

        // Remaining table rows, including both saturation directions.
        for (int i = 3; i < 8; i++) begin
            load_coeffs(vecs[i]);
            run_frame(vecs[i], 1'b0);
        end

        // Reset in the middle of a frame wipes state and coefficients.
        load_coeffs(vecs[1]);
        for (int k = 0; k < 7; k++) send_beat({4{8'd3}});
        check("mid_frame_busy", longint'(bus24.busy), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", longint'(bus24.busy), 0);
        check("mid_rst_in_ready", longint'(bus24.in_ready), 0);
        check("mid_rst_busy16", longint'(bus16.busy), 0);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ready_after", longint'(bus24.in_ready), 1);
        run_frame(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0, 0, 0, 0), 1'b0);

        begin
            int guard = 0;
            while ((sb24.size() != 0 || sb16.size() != 0) && guard < TIMEOUT) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        check("sb24_drained", sb24.size(), 0);
        check("sb16_drained", sb16.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
